// File: rtl/wb_pkg.sv
// Shared Wishbone types and constants for the on-chip memory responder.
package wb_pkg;

  localparam int WB_ADDR_W = 30;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [WB_DATA_W-1:0] data;
  } wb_resp_t;

  localparam wb_resp_t WB_RESP_IDLE = '{valid: 1'b0, err: 1'b0, data: {WB_DATA_W{1'b0}}};

  // True when the word address lies beyond a 2**idx_w word array.
  function automatic logic addr_out_of_range(input logic [WB_ADDR_W-1:0] addr,
                                             input int unsigned          idx_w);
    return (addr >> idx_w) != {WB_ADDR_W{1'b0}};
  endfunction

endpackage

// File: rtl/wb_mem_array.sv
// DEPTH x 32 synchronous RAM with per-byte write enables and read-before-write
// output register; contents start at zero.
module wb_mem_array
  import wb_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic                     i_clk,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [WB_SEL_W-1:0]      i_sel,
  input  logic [WB_DATA_W-1:0]     i_wdata,
  output logic [WB_DATA_W-1:0]     o_rdata
);

  logic [WB_DATA_W-1:0] r_mem [DEPTH];
  logic [WB_DATA_W-1:0] r_rdata;

  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = {WB_DATA_W{1'b0}};
  end

  // The read register captures the old word, so a same-edge write is not visible.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_idx];
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (i_we && i_sel[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B4 pipelined responder over wb_mem_array with fixed response latency
// and programmable post-accept stall. WB_MEM_RANGE_CHECK_EN turns out-of-range accesses into err.
module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int LATENCY      = 1,
  parameter int STALL_CYCLES = 0,
  parameter     INIT_FILE    = ""
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [WB_ADDR_W-1:0] wb_addr_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  input  logic [WB_DATA_W-1:0] wb_data_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_stall_o,
  output logic [WB_DATA_W-1:0] wb_data_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic                 w_accept;
  logic                 w_oob;
  logic                 w_mem_we;
  logic [WB_DATA_W-1:0] w_rdata;
  logic                 r_vld0;
  logic                 r_err0;
  wb_resp_t             w_head;
  wb_resp_t             w_tail;

  assign w_accept = wb_cyc_i & wb_stb_i & ~wb_stall_o;

`ifdef WB_MEM_RANGE_CHECK_EN
  assign w_oob = addr_out_of_range(wb_addr_i, IDX_W);
`else
  logic w_unused_hi;
  assign w_oob       = 1'b0;
  assign w_unused_hi = addr_out_of_range(wb_addr_i, IDX_W);
`endif

  assign w_mem_we = wb_we_i & ~w_oob;

  wb_mem_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .i_clk   (clk_i),
    .i_en    (w_accept),
    .i_we    (w_mem_we),
    .i_idx   (wb_addr_i[IDX_W-1:0]),
    .i_sel   (wb_sel_i),
    .i_wdata (wb_data_i),
    .o_rdata (w_rdata)
  );

  // First response stage: its data rides in the RAM output register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_vld0 <= 1'b0;
      r_err0 <= 1'b0;
    end else if (!wb_cyc_i) begin
      r_vld0 <= 1'b0;
      r_err0 <= 1'b0;
    end else begin
      r_vld0 <= w_accept;
      r_err0 <= w_accept & w_oob;
    end
  end

  always_comb begin
    w_head       = WB_RESP_IDLE;
    w_head.valid = r_vld0;
    w_head.err   = r_err0;
    if (r_vld0 && !r_err0) begin
      w_head.data = w_rdata;
    end else begin
      w_head.data = {WB_DATA_W{1'b0}};
    end
  end

  if (LATENCY > 1) begin : g_pipe
    wb_resp_t r_pipe [LATENCY-1];

    // Remaining latency stages; dropping cyc flushes every in-flight response.
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        for (int k = 0; k < LATENCY-1; k++) r_pipe[k] <= WB_RESP_IDLE;
      end else if (!wb_cyc_i) begin
        for (int k = 0; k < LATENCY-1; k++) r_pipe[k] <= WB_RESP_IDLE;
      end else begin
        r_pipe[0] <= w_head;
        for (int k = 1; k < LATENCY-1; k++) r_pipe[k] <= r_pipe[k-1];
      end
    end

    assign w_tail = r_pipe[LATENCY-2];
  end else begin : g_nopipe
    assign w_tail = w_head;
  end

  if (STALL_CYCLES == 0) begin : g_nostall
    assign wb_stall_o = 1'b0;
  end else begin : g_stall
    localparam int            CW     = $clog2(STALL_CYCLES + 1);
    localparam logic [CW-1:0] C_ZERO = CW'(0);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LOAD = CW'(STALL_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_stall;

    always_comb begin
      w_cnt_nxt = r_cnt;
      if (!wb_cyc_i) begin
        w_cnt_nxt = C_ZERO;
      end else if (w_accept) begin
        w_cnt_nxt = C_LOAD;
      end else if (r_cnt != C_ZERO) begin
        w_cnt_nxt = r_cnt - C_ONE;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end

    // Stall flag is registered alongside the counter so it is glitch-free.
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        r_cnt   <= C_ZERO;
        r_stall <= 1'b0;
      end else begin
        r_cnt   <= w_cnt_nxt;
        r_stall <= (w_cnt_nxt != C_ZERO);
      end
    end

    assign wb_stall_o = r_stall;
  end

  // Responses are masked by cyc so an abort silences them in the same cycle.
  always_comb begin
    wb_ack_o = wb_cyc_i & w_tail.valid & ~w_tail.err;
    wb_err_o = wb_cyc_i & w_tail.valid &  w_tail.err;
    if (wb_ack_o) begin
      wb_data_o = w_tail.data;
    end else begin
      wb_data_o = {WB_DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Scoreboard bench: four responder instances with different latency/stall settings.
module tb_wb_mem_responder;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    int          inst;
    bit          err;
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cyc_s = 4'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [29:0] addr = 30'd0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdata = 32'h0;
  wire  [3:0]  ack_s;
  wire  [3:0]  err_s;
  wire  [3:0]  stall_s;
  wire  [31:0] rdata_s [4];

  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wb_mem_responder #(
      .DEPTH        (1024),
      .LATENCY      (lat_of(g)),
      .STALL_CYCLES ((g == 2) ? 2 : 0),
      .INIT_FILE    ("")
    ) u_dut (
      .clk_i      (clk),
      .reset_ni   (rst_n),
      .wb_cyc_i   (cyc_s[g]),
      .wb_stb_i   (stb),
      .wb_we_i    (we),
      .wb_addr_i  (addr),
      .wb_sel_i   (sel),
      .wb_data_i  (wdata),
      .wb_ack_o   (ack_s[g]),
      .wb_err_o   (err_s[g]),
      .wb_stall_o (stall_s[g]),
      .wb_data_o  (rdata_s[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc_n);
    end
  endtask

  // Issue one request to instance inst; stb stays high so calls chain back-to-back.
  task automatic req(input int inst, input bit w, input logic [29:0] a, input logic [3:0] s,
                     input logic [31:0] d, input bit xerr, input logic [31:0] xdata, input bit xchk);
    cyc_s = 4'b0;
    cyc_s[inst] = 1'b1;
    stb = 1'b1; we = w; addr = a; sel = s; wdata = d;
    @(posedge clk); #1;
    q.push_back('{inst: inst, err: xerr, data: xdata, chk: xchk, due: cyc_n + lat_of(inst) - 1});
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever any instance responds.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (ack_s[i] || err_s[i]) begin
          chk("ack_err_exclusive", {31'b0, ack_s[i] & err_s[i]}, 32'h0);
          if (q.size() == 0) begin
            chk("unexpected_resp_inst", 32'(i), 32'hFFFF_FFFF);
          end else begin
            mon_e = q.pop_front();
            chk("resp_inst", 32'(i), 32'(mon_e.inst));
            chk("resp_err", {31'b0, err_s[i]}, {31'b0, mon_e.err});
            chk("resp_cycle", 32'(cyc_n), 32'(mon_e.due));
            if (mon_e.chk) chk("resp_data", rdata_s[i], mon_e.data);
          end
        end else begin
          chk("idle_data_zero", rdata_s[i], 32'h0);
        end
        if (i != 2) chk("stall_tied_low", {31'b0, stall_s[i]}, 32'h0);
      end
      if (q.size() > 0 && q[0].due < cyc_n) begin
        mon_e = q.pop_front();
        chk("resp_missing_due", 32'(mon_e.due), 32'(cyc_n));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic xs;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_ack", {31'b0, ack_s[i]}, 32'h0);
      chk("rst_err", {31'b0, err_s[i]}, 32'h0);
      chk("rst_stall", {31'b0, stall_s[i]}, 32'h0);
      chk("rst_data", rdata_s[i], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency 1: write then read, byte lanes, sel=0 no-op.
    req(0, 1'b1, 30'd5, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    req(0, 1'b0, 30'd5, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    req(0, 1'b1, 30'd5, 4'h5, 32'h1122_3344, 1'b0, 32'h0, 1'b0);
    req(0, 1'b0, 30'd5, 4'hF, 32'h0, 1'b0, 32'hDE22_BE44, 1'b1);
    req(0, 1'b1, 30'd5, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    req(0, 1'b0, 30'd5, 4'hF, 32'h0, 1'b0, 32'hDE22_BE44, 1'b1);
    idle(1);

    // Address range handling.
    req(0, 1'b1, 30'd0, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
`ifdef WB_MEM_RANGE_CHECK_EN
    req(0, 1'b1, 30'd1024, 4'hF, 32'h1234_5678, 1'b1, 32'h0, 1'b0);
    req(0, 1'b0, 30'd1024, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1);
    req(0, 1'b0, 30'd0, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1);
`else
    req(0, 1'b1, 30'd1024, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    req(0, 1'b0, 30'd1024, 4'hF, 32'h0, 1'b0, 32'h1234_5678, 1'b1);
    req(0, 1'b0, 30'd0, 4'hF, 32'h0, 1'b0, 32'h1234_5678, 1'b1);
`endif
    idle(4);

    // Latency 3: fill words 0..3 then four back-to-back reads.
    for (int k = 0; k < 4; k++) req(1, 1'b1, 30'(k), 4'hF, 32'(k), 1'b0, 32'h0, 1'b0);
    idle(4);
    for (int k = 0; k < 4; k++) req(1, 1'b0, 30'(k), 4'hF, 32'h0, 1'b0, 32'(k), 1'b1);
    idle(6);

    // Stall spacing of 2 cycles (latency 2).
    req(2, 1'b1, 30'd0, 4'hF, 32'h0000_AAAA, 1'b0, 32'h0, 1'b0);
    idle(3);
    req(2, 1'b1, 30'd3, 4'hF, 32'h0000_BBBB, 1'b0, 32'h0, 1'b0);
    idle(3);
    stb = 1'b1; we = 1'b0; sel = 4'hF;
    for (int k = 0; k < 6; k++) begin
      addr = 30'(k);
      xs = (k == 1 || k == 2 || k == 4 || k == 5);
      chk("stall_pattern", {31'b0, stall_s[2]}, {31'b0, xs});
      @(posedge clk); #1;
      if (!xs) q.push_back('{inst: 2, err: 1'b0, data: (k == 0) ? 32'h0000_AAAA : 32'h0000_BBBB,
                             chk: 1'b1, due: cyc_n + 1});
    end
    idle(5);

    // Latency 4: abort by dropping cyc, then by reset.
    req(3, 1'b1, 30'd10, 4'hF, 32'hA0A0_0001, 1'b0, 32'h0, 1'b0);
    req(3, 1'b1, 30'd11, 4'hF, 32'hA0A0_0002, 1'b0, 32'h0, 1'b0);
    idle(6);
    req(3, 1'b0, 30'd10, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    req(3, 1'b0, 30'd11, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(1);
    cyc_s[3] = 1'b0;
    q = q.find(x) with (x.inst != 3);
    @(posedge clk); #1;
    cyc_s[3] = 1'b1;
    idle(8);
    req(3, 1'b0, 30'd11, 4'hF, 32'h0, 1'b0, 32'hA0A0_0002, 1'b1);
    idle(6);
    req(3, 1'b0, 30'd10, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    req(3, 1'b0, 30'd11, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(1);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(8);
    req(3, 1'b0, 30'd10, 4'hF, 32'h0, 1'b0, 32'hA0A0_0001, 1'b1);
    idle(1);

    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
